// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads over a req/gnt port and buffers
// PC-tagged responses in a small prefetch FIFO feeding decode.
module instr_fetch_unit #(
   parameter int unsigned PC_W   = 8,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [PC_W-1:0]   instr_pc,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              inflight_q, inflight_d;
   logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
   logic              inflight_epoch_q, inflight_epoch_d;
   logic              epoch_q, epoch_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
   logic [DATA_W-1:0] fifo_data_q [DEPTH];
   logic [DATA_W-1:0] fifo_data_d [DEPTH];
   logic [PC_W-1:0]   fifo_pc_q [DEPTH];
   logic [PC_W-1:0]   fifo_pc_d [DEPTH];

   logic              accept;
   logic              push;
   logic              pop;
   logic              credit_ok;
   logic [CNT_W:0]    credit_used;
   logic [CNT_W-1:0]  cnt_after_pop;

   // An outstanding response holds a slot until it has actually been written.
   assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign credit_ok   = credit_used < {1'b0, FULL_CNT};

   assign imem_req    = rst && fetch_en && !redirect && credit_ok;
   assign imem_addr   = ADDR_W'(fetch_pc_q);
   assign accept      = imem_req && imem_gnt;

   assign instr_valid = (count_q != '0);
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;

   assign push = inflight_q && (inflight_epoch_q == epoch_q) && !redirect;
   assign pop  = instr_valid && instr_ready && !redirect;

   always_comb begin
      fetch_pc_d       = fetch_pc_q;
      rd_ptr_d         = rd_ptr_q;
      wr_ptr_d         = wr_ptr_q;
      count_d          = count_q;
      inflight_d       = 1'b0;
      inflight_pc_d    = inflight_pc_q;
      inflight_epoch_d = inflight_epoch_q;
      epoch_d          = epoch_q;
      fifo_data_d      = fifo_data_q;
      fifo_pc_d        = fifo_pc_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         epoch_d    = ~epoch_q;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (accept) begin
            fetch_pc_d       = fetch_pc_q + PC_W'(1);
            inflight_d       = 1'b1;
            inflight_pc_d    = fetch_pc_q;
            inflight_epoch_d = epoch_q;
         end
         if (push) begin
            fifo_data_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Head registers track the entry that will be at the head after this edge.
   assign cnt_after_pop = count_q - CNT_W'(pop);

   always_comb begin
      instr_d    = '0;
      instr_pc_d = '0;
      if (count_d != '0) begin
         if (cnt_after_pop == '0) begin
            instr_d    = imem_rdata;
            instr_pc_d = inflight_pc_q;
         end else begin
            instr_d    = fifo_data_q[rd_ptr_d];
            instr_pc_d = fifo_pc_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q       <= '0;
         rd_ptr_q         <= '0;
         wr_ptr_q         <= '0;
         count_q          <= '0;
         inflight_q       <= 1'b0;
         inflight_pc_q    <= '0;
         inflight_epoch_q <= 1'b0;
         epoch_q          <= 1'b0;
         instr_q          <= '0;
         instr_pc_q       <= '0;
         fifo_data_q      <= '{default: '0};
         fifo_pc_q        <= '{default: '0};
      end else begin
         fetch_pc_q       <= fetch_pc_d;
         rd_ptr_q         <= rd_ptr_d;
         wr_ptr_q         <= wr_ptr_d;
         count_q          <= count_d;
         inflight_q       <= inflight_d;
         inflight_pc_q    <= inflight_pc_d;
         inflight_epoch_q <= inflight_epoch_d;
         epoch_q          <= epoch_d;
         instr_q          <= instr_d;
         instr_pc_q       <= instr_pc_d;
         fifo_data_q      <= fifo_data_d;
         fifo_pc_q        <= fifo_pc_d;
      end
   end

   assert property (@(posedge clk) disable iff (!rst) push |-> (count_q != FULL_CNT));
   assert property (@(posedge clk) disable iff (!rst) count_q <= FULL_CNT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder plus PC-ordered scoreboard,
// with one task per scenario.
module tb_instr_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [7:0]  redirect_pc;

   int checks = 0;
   int failures = 0;

   logic [39:0] sb [$];
   logic [7:0]  exp_pc = 8'h00;
   int          accept_cnt = 0;
   logic [31:0] rdata_nxt = 32'h0;

   instr_fetch_unit #(
      .PC_W   (8),
      .ADDR_W (16),
      .DATA_W (32),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_en    (fetch_en),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= rdata_nxt;

   // Sees the inputs the next posedge will act on; memory[i] = 0x1000_0000 + i.
   always @(negedge clk) begin
      logic [39:0] exp;
      #2;
      rdata_nxt = 32'hDEAD_BEEF;
      if (!rst) begin
         sb.delete();
         exp_pc     = 8'h00;
         accept_cnt = 0;
      end else if (redirect) begin
         sb.delete();
         exp_pc = redirect_pc;
      end else begin
         if (instr_valid && instr_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got pc=%h instr=%h, expected nothing", instr_pc,
                        instr);
            end else begin
               exp = sb.pop_front();
               if ({instr, instr_pc} !== exp) begin
                  failures++;
                  $display("FAIL sb_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                           instr_pc, instr, exp[7:0], exp[39:8]);
               end
            end
         end
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== {8'h00, exp_pc}) begin
               failures++;
               $display("FAIL accept_addr: got %h, expected %h", imem_addr, {8'h00, exp_pc});
            end
            rdata_nxt = 32'h1000_0000 + {16'h0, imem_addr};
            sb.push_back({32'h1000_0000 + {24'h0, exp_pc}, exp_pc});
            exp_pc = exp_pc + 8'h01;
            accept_cnt++;
            checks++;
            if (sb.size() > DEPTH) begin
               failures++;
               $display("FAIL credit: outstanding=%0d, expected <= %0d", sb.size(), DEPTH);
            end
         end
      end
   end

   task automatic pulse_reset();
      @(negedge clk);
      rst      = 1'b0;
      fetch_en = 1'b0;
      redirect = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 5;
      if (instr_valid !== 1'b0) begin
         failures++; $display("FAIL rst_valid: got %b, expected 0", instr_valid);
      end
      if (instr !== 32'h0) begin
         failures++; $display("FAIL rst_instr: got %h, expected 0", instr);
      end
      if (instr_pc !== 8'h0) begin
         failures++; $display("FAIL rst_pc: got %h, expected 0", instr_pc);
      end
      if (imem_req !== 1'b0) begin
         failures++; $display("FAIL rst_req: got %b, expected 0", imem_req);
      end
      if (imem_addr !== 16'h0) begin
         failures++; $display("FAIL rst_addr: got %h, expected 0", imem_addr);
      end
      rst = 1'b1;
   endtask

   task automatic test_stream();
      @(negedge clk);
      fetch_en = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
         failures++;
         $display("FAIL stream_req: got req=%b addr=%h, expected 1/0000", imem_req, imem_addr);
      end
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++; $display("FAIL stream_lat1: got valid=%b, expected 0", instr_valid);
      end
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr !== 32'h1000_0000 + 32'(k))
         begin
            failures++;
            $display("FAIL stream_seq: got valid=%b pc=%h instr=%h, expected 1 pc=%h", instr_valid,
                     instr_pc, instr, 8'(k));
         end
      end
   endtask

   task automatic test_stall();
      pulse_reset();
      fetch_en    = 1'b1;
      instr_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (instr_valid) begin
            checks++;
            if (instr_pc !== 8'h00 || instr !== 32'h1000_0000) begin
               failures++;
               $display("FAIL stall_hold: got pc=%h instr=%h, expected 00/10000000", instr_pc,
                        instr);
            end
         end
      end
      checks += 2;
      if (accept_cnt != DEPTH) begin
         failures++; $display("FAIL stall_accepts: got %0d, expected %0d", accept_cnt, DEPTH);
      end
      if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_full: got req=%b valid=%b, expected 0/1", imem_req, instr_valid);
      end
      instr_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 8'(k)) begin
            failures++;
            $display("FAIL stall_drain: got valid=%b pc=%h, expected 1/%h", instr_valid, instr_pc,
                     8'(k));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_gnt_toggle();
      logic        prev_gnt;
      logic        prev_req;
      logic [15:0] prev_addr;
      logic [7:0]  last_pc;
      logic        have_last;
      have_last = 1'b0;
      prev_gnt  = 1'b1;
      prev_req  = 1'b0;
      prev_addr = 16'h0;
      last_pc   = 8'h0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (!prev_gnt && prev_req) begin
            checks++;
            if (imem_addr !== prev_addr) begin
               failures++;
               $display("FAIL gnt_hold: got addr=%h, expected %h", imem_addr, prev_addr);
            end
         end
         if (instr_valid && instr_ready) begin
            if (have_last) begin
               checks++;
               if (instr_pc !== last_pc + 8'h01) begin
                  failures++;
                  $display("FAIL gnt_contig: got pc=%h, expected %h", instr_pc, last_pc + 8'h01);
               end
            end
            have_last = 1'b1;
            last_pc   = instr_pc;
         end
         imem_gnt = (k % 2) == 1;
         #1;
         prev_gnt  = imem_gnt;
         prev_req  = imem_req;
         prev_addr = imem_addr;
      end
      @(negedge clk);
      imem_gnt = 1'b1;
   endtask

   task automatic test_redirect();
      bit found;
      pulse_reset();
      fetch_en    = 1'b1;
      instr_ready = 1'b0;
      found       = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (accept_cnt == 4) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
         failures++;
         $display("FAIL redir_setup: got accepts=%0d valid=%b pc=%h, expected 4/1/00",
                  accept_cnt, instr_valid, instr_pc);
      end
      redirect    = 1'b1;
      redirect_pc = 8'h40;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         failures++; $display("FAIL redir_req: got %b, expected 0", imem_req);
      end
      @(negedge clk);
      redirect    = 1'b0;
      instr_ready = 1'b1;
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++; $display("FAIL redir_flush: got valid=%b, expected 0", instr_valid);
      end
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++; $display("FAIL redir_stale: got valid=%b, expected 0", instr_valid);
      end
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h40 || instr !== 32'h1000_0040) begin
         failures++;
         $display("FAIL redir_first: got valid=%b pc=%h instr=%h, expected 1/40/10000040",
                  instr_valid, instr_pc, instr);
      end
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h41) begin
         failures++;
         $display("FAIL redir_second: got valid=%b pc=%h, expected 1/41", instr_valid, instr_pc);
      end
   endtask

   task automatic test_wrap();
      logic [7:0]  exp_w [4];
      logic [15:0] addrs [4];
      logic [7:0]  pcs [4];
      int          na;
      int          nd;
      exp_w = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      addrs = '{default: 16'hFFFF};
      pcs   = '{default: 8'hAA};
      na    = 0;
      nd    = 0;
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 8'hFE;
      @(negedge clk);
      redirect = 1'b0;
      for (int cyc = 0; cyc < 20 && nd < 4; cyc++) begin
         #1;
         if (imem_req && imem_gnt && na < 4) begin
            addrs[na] = imem_addr;
            na++;
         end
         if (instr_valid && instr_ready && nd < 4) begin
            pcs[nd] = instr_pc;
            nd++;
         end
         @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (addrs[k] !== {8'h00, exp_w[k]} || pcs[k] !== exp_w[k]) begin
            failures++;
            $display("FAIL wrap_%0d: got addr=%h pc=%h, expected %h/%h", k, addrs[k], pcs[k],
                     {8'h00, exp_w[k]}, exp_w[k]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      instr_ready = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_full: got req=%b valid=%b, expected 0/1", imem_req, instr_valid);
      end
      rst      = 1'b0;
      fetch_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 8'h0 || imem_req !== 1'b0 ||
          imem_addr !== 16'h0) begin
         failures++;
         $display("FAIL mid_rst: got valid=%b instr=%h pc=%h req=%b addr=%h, expected all 0",
                  instr_valid, instr, instr_pc, imem_req, imem_addr);
      end
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
         failures++;
         $display("FAIL mid_restart: got req=%b addr=%h, expected 1/0000", imem_req, imem_addr);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== 32'h1000_0000) begin
         failures++;
         $display("FAIL mid_first: got valid=%b pc=%h instr=%h, expected 1/00/10000000",
                  instr_valid, instr_pc, instr);
      end
   endtask

   initial begin
      rst         = 1'b0;
      fetch_en    = 1'b0;
      imem_gnt    = 1'b1;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      test_reset();
      test_stream();
      test_stall();
      test_gnt_toggle();
      test_redirect();
      test_wrap();
      test_reset_midstream();
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
